// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: BIN_W-bit unsigned binary to DIGITS packed BCD digits.
// The result and overflow flag hold steady until the next conversion completes.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BCD_W = DIGITS * 4;
    localparam int SCR_W = BCD_W + 4;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    function automatic int unsigned pow10(input int n);
        int unsigned p;
        p = 32'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p;
    endfunction

    localparam int unsigned MAX_VAL = pow10(DIGITS) - 32'd1;

    // One double-dabble step: add 3 to every nibble >= 5 (pre-shift values), then shift in bit_in.
    function automatic logic [SCR_W-1:0] dabble_step(input logic [SCR_W-1:0] scr, input logic bit_in);
        logic [SCR_W-1:0] adj;
        adj = scr;
        for (int i = 0; i < SCR_W / 4; i++) begin
            if (scr[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = scr[i*4 +: 4] + 4'd3;
            end else begin
                adj[i*4 +: 4] = scr[i*4 +: 4];
            end
        end
        return {adj[SCR_W-2:0], bit_in};
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BIN_W-1:0]   r_shift;
    logic [SCR_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_pend;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [SCR_W-1:0]   w_scr_nxt;
    logic [31:0]        w_bin_ext;
    logic               w_in_ovf;

    assign w_scr_nxt = dabble_step(r_scratch, r_shift[BIN_W-1]);
    assign w_bin_ext = 32'(bin_in);
    assign w_in_ovf  = (w_bin_ext > MAX_VAL);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == LAST_ITER) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so busy/done can be registered without extra latency
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_SHIFT: w_busy_nxt = 1'b1;
            S_DONE:  w_done_nxt = 1'b1;
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Handshake output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Conversion datapath and held result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift    <= {BIN_W{1'b0}};
            r_scratch  <= {SCR_W{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_ovf_pend <= 1'b0;
            r_bcd      <= {BCD_W{1'b0}};
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift    <= bin_in;
                        r_scratch  <= {SCR_W{1'b0}};
                        r_cnt      <= {CNT_W{1'b0}};
                        r_ovf_pend <= w_in_ovf;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_scr_nxt;
                    r_shift   <= {r_shift[BIN_W-2:0], 1'b0};
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_bcd <= r_ovf_pend ? ALL_NINES : w_scr_nxt[BCD_W-1:0];
                        r_ovf <= r_ovf_pend;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd_out  = r_bcd;
    assign overflow = r_ovf;

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential double-dabble (shift-add-3) converter from a 14-bit binary value to 4 packed BCD digits.
- Sits directly upstream of the four-digit seven-segment driver on the board display path and supplies its digit values.
- Replaces per-digit divide/modulo logic with a small iterative datapath.
- Uses a start/busy/done handshake and holds its result stable between conversions.

Parameters:
- BIN_W, 14, width of the binary input; also the number of shift iterations.
- DIGITS, 4, number of BCD output digits; bcd_out is DIGITS*4 bits wide.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, active-low, asynchronous.
- start  input  1  conversion request; sampled on the rising edge.
- bin_in  input  BIN_W  unsigned binary value; captured on the accepted start edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out and overflow update.
- bcd_out  output  DIGITS*4  packed BCD result; [3:0] = units, [15:12] = thousands.
- overflow  output  1  high when the last captured value exceeded 10^DIGITS-1; updates with bcd_out.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While rst=0: state=IDLE, busy=0, done=0, bcd_out=0, overflow=0. The scratch register, shift register and iteration counter are all cleared.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge k:
  - capture bin_in into the shift register;
  - clear the BCD scratch (DIGITS*4 bits plus 4 guard bits, so 16383 does not wrap);
  - counter=0, state=SHIFT;
  - latch ovf_pend = (bin_in > 10^DIGITS-1).
- SHIFT, each edge:
  - every scratch nibble >= 5 gets +3 (all nibbles evaluated in parallel, using pre-shift values);
  - then {scratch, shift} shifts left by 1;
  - counter increments.
- Final SHIFT iteration at edge k+BIN_W (edge k+14 at defaults):
  - state=DONE;
  - bcd_out = ovf_pend ? all-9s (16'h9999) : low DIGITS*4 bits of the updated scratch;
  - overflow = ovf_pend.
- DONE lasts one cycle: done=1 and busy=0. The next edge returns state to IDLE and done to 0.
- busy=1 in SHIFT only. Between edge k and edge k+14, busy=1 for exactly BIN_W cycles.
- Latency: result is valid and done=1 in the cycle following edge k+BIN_W, i.e. BIN_W+1 cycles after the start edge.
- start while in SHIFT or DONE: ignored, with no queuing and no effect on the result.
  - Minimum spacing between accepted starts is therefore BIN_W+2 cycles (16 at defaults).
  - A start held high continuously re-triggers every BIN_W+2 cycles.
- bin_in changes after the capture edge do not affect the current conversion.
- bcd_out and overflow hold their last value in IDLE, SHIFT and DONE until the next DONE entry. The downstream driver can read them at any time without glitches.
- Each output nibble is always in 0..9.
- Reset asserted mid-SHIFT: immediate abort. All outputs return to reset values (the previous bcd_out is lost), and there is no done pulse.
- Input 0 produces bcd_out=0 with the normal latency; there is no shortcut.
- All arithmetic is unsigned. The nibble add-3 cannot overflow a nibble, because a nibble >= 5 becomes 8..12 before the shift.

Test Plan:
- Reset, then start with bin_in=0 -> done pulses exactly 15 cycles after the start edge; bcd_out=16'h0000, overflow=0; busy high for 14 cycles.
- bin_in=1234, start pulse -> bcd_out=16'h1234, overflow=0; done high for exactly 1 cycle; bcd_out still 16'h1234 20 cycles later.
- bin_in=9999 then, after done, bin_in=10000 -> first result 16'h9999 with overflow=0; second result 16'h9999 with overflow=1. Follow with bin_in=16383 -> 16'h9999, overflow=1.
- bin_in=507, start; at cycle 5 set bin_in=42 and pulse start again -> second start ignored; bcd_out=16'h0507; exactly one done pulse.
- start held high with bin_in=88 -> done pulses every 16 cycles, each with bcd_out=16'h0088; busy never high in a done cycle.
- Convert 4321 (bcd_out=16'h4321), start 600, assert rst low at cycle 7 for 2 cycles -> busy, done, bcd_out and overflow go to 0 asynchronously with no done pulse. A subsequent start with 600 gives bcd_out=16'h0600.
